// File: rtl/adc_sched_pkg.sv
// Shared types and default sizing for the ADC channel scheduler.
package adc_sched_pkg;

   localparam int unsigned NUM_CH  = 8;
   localparam int unsigned CH_W    = 3;
   localparam int unsigned DATA_W  = 12;
   localparam int unsigned GAP_W   = 16;
   localparam int unsigned TIMEOUT = 4096;
   localparam int unsigned TO_W    = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/adc_channel_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 3
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] grant_c,
   output logic         valid_c
);

   int unsigned idx;
   logic        found;

   always_comb begin
      grant_c = '0;
      found   = 1'b0;
      idx     = 0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx = (32'(ptr) + i) % N;
         if (!found && req[W'(idx)]) begin
            grant_c = W'(idx);
            found   = 1'b1;
         end
      end
   end

   assign valid_c = |req;

endmodule

// File: rtl/adc_channel_scheduler.sv
// Round-robin scheduler sharing one ADC engine among per-channel requesters,
// with a post-response idle gap and a per-conversion watchdog.
module adc_channel_scheduler #(
   parameter int unsigned NUM_CH  = adc_sched_pkg::NUM_CH,
   parameter int unsigned CH_W    = adc_sched_pkg::CH_W,
   parameter int unsigned DATA_W  = adc_sched_pkg::DATA_W,
   parameter int unsigned GAP_W   = adc_sched_pkg::GAP_W,
   parameter int unsigned TIMEOUT = adc_sched_pkg::TIMEOUT
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] req,
   input  logic [NUM_CH-1:0] enable,
   input  logic [GAP_W-1:0]  min_gap,
   output logic [NUM_CH-1:0] ack,
   output logic [DATA_W-1:0] result,
   output logic              err,
   output logic              sched_busy,
   output logic              conv_start,
   output logic [CH_W-1:0]   conv_ch,
   input  logic              conv_busy,
   input  logic              conv_done,
   input  logic [DATA_W-1:0] conv_data
);
   import adc_sched_pkg::*;

   localparam int unsigned TO_W = $clog2(TIMEOUT);

   sched_state_e      state, state_nxt;
   logic [GAP_W-1:0]  gap_cnt, gap_nxt;
   logic [CH_W-1:0]   ptr, ptr_nxt;
   logic [TO_W-1:0]   to_cnt, to_nxt;
   logic [NUM_CH-1:0] ack_nxt;
   logic [DATA_W-1:0] result_nxt;
   logic              err_nxt;
   logic              busy_nxt;
   logic              start_nxt;
   logic [CH_W-1:0]   ch_nxt;
   logic [CH_W-1:0]   arb_grant;
   logic              arb_valid;

   rr_arbiter #(.N(NUM_CH), .W(CH_W)) u_arb (
      .req     (req & enable),
      .ptr     (ptr),
      .grant_c (arb_grant),
      .valid_c (arb_valid)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         gap_cnt    <= '0;
         ptr        <= CH_W'(NUM_CH - 1);
         to_cnt     <= '0;
         ack        <= '0;
         result     <= '0;
         err        <= 1'b0;
         sched_busy <= 1'b0;
         conv_start <= 1'b0;
         conv_ch    <= '0;
      end else begin
         state      <= state_nxt;
         gap_cnt    <= gap_nxt;
         ptr        <= ptr_nxt;
         to_cnt     <= to_nxt;
         ack        <= ack_nxt;
         result     <= result_nxt;
         err        <= err_nxt;
         sched_busy <= busy_nxt;
         conv_start <= start_nxt;
         conv_ch    <= ch_nxt;
      end
   end

   // Outputs are computed one state ahead so they land registered in the target state.
   always_comb begin
      state_nxt  = state;
      gap_nxt    = gap_cnt;
      ptr_nxt    = ptr;
      to_nxt     = to_cnt;
      ack_nxt    = '0;
      result_nxt = result;
      err_nxt    = err;
      start_nxt  = 1'b0;
      ch_nxt     = conv_ch;

      case (state)
         IDLE: begin
            if (gap_cnt != '0) begin
               gap_nxt = gap_cnt - 1'b1;
            end else if (!conv_busy && arb_valid) begin
               ch_nxt    = arb_grant;
               ptr_nxt   = arb_grant;
               start_nxt = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            to_nxt    = '0;
            state_nxt = WAIT;
         end
         WAIT: begin
            to_nxt = to_cnt + 1'b1;
            // A requester that withdrew keeps its turn consumed but gets no ACK.
            if (conv_done) begin
               result_nxt = conv_data;
               err_nxt    = 1'b0;
               ack_nxt    = req[conv_ch] ? (NUM_CH'(1) << conv_ch) : '0;
               state_nxt  = RESP;
            end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
               result_nxt = '0;
               err_nxt    = 1'b1;
               ack_nxt    = req[conv_ch] ? (NUM_CH'(1) << conv_ch) : '0;
               state_nxt  = RESP;
            end
         end
         RESP: begin
            gap_nxt   = min_gap;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Directed bench for adc_channel_scheduler with a fixed-latency ADC engine model.
module tb_adc_channel_scheduler;

   localparam int unsigned NUM_CH  = 8;
   localparam int unsigned CH_W    = 3;
   localparam int unsigned DATA_W  = 12;
   localparam int unsigned GAP_W   = 16;
   localparam int unsigned TIMEOUT = 64;
   localparam int          ENG_LAT = 20;

   logic              clock = 1'b0;
   logic              reset_n;
   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] enable;
   logic [GAP_W-1:0]  min_gap;
   logic [NUM_CH-1:0] ack;
   logic [DATA_W-1:0] result;
   logic              err;
   logic              sched_busy;
   logic              conv_start;
   logic [CH_W-1:0]   conv_ch;
   logic              conv_busy;
   logic              conv_done;
   logic [DATA_W-1:0] conv_data;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;
   bit eng_hang = 1'b0;
   logic [CH_W-1:0] eng_ch;

   adc_channel_scheduler #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .GAP_W(GAP_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req        (req),
      .enable     (enable),
      .min_gap    (min_gap),
      .ack        (ack),
      .result     (result),
      .err        (err),
      .sched_busy (sched_busy),
      .conv_start (conv_start),
      .conv_ch    (conv_ch),
      .conv_busy  (conv_busy),
      .conv_done  (conv_done),
      .conv_data  (conv_data)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic wait_start(input int max, output int c);
      int n;
      c = -1;
      n = 0;
      while (c < 0 && n < max) begin
         @(negedge clock);
         n++;
         if (conv_start === 1'b1) c = cyc;
      end
      if (c < 0) check("start_wait_expired", 32'd0, 32'd1);
   endtask

   task automatic wait_ack(input int max, output int c);
      int n;
      c = -1;
      n = 0;
      while (c < 0 && n < max) begin
         @(negedge clock);
         n++;
         if (ack !== '0) c = cyc;
      end
      if (c < 0) check("ack_wait_expired", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Engine model: DONE pulse ENG_LAT cycles after START, data = 0x100 + channel.
   initial begin
      conv_done = 1'b0;
      conv_data = '0;
      eng_ch    = '0;
      forever begin
         @(negedge clock);
         if (conv_start === 1'b1) begin
            eng_ch = conv_ch;
            repeat (ENG_LAT) @(negedge clock);
            if (!eng_hang) begin
               conv_done = 1'b1;
               conv_data = 12'h100 + {9'd0, eng_ch};
               @(negedge clock);
               conv_done = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int s, a, a2, s2, b, r;
      int exp_ch[5] = '{0, 2, 5, 7, 0};
      bit seen_start, seen_busy, seen_ack, seen_dirty;

      reset_n   = 1'b0;
      req       = 8'hFF;
      enable    = 8'hFF;
      min_gap   = '0;
      conv_busy = 1'b0;

      // Reset values, then first grant one cycle after release
      repeat (3) @(negedge clock);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_start", 32'(conv_start), 32'd0);
      check("rst_ch", 32'(conv_ch), 32'd0);
      check("rst_busy", 32'(sched_busy), 32'd0);
      reset_n = 1'b1;
      r = cyc;
      @(negedge clock);
      check("first_start", 32'(conv_start), 32'd1);
      check("first_ch", 32'(conv_ch), 32'd0);
      check("first_start_cycle", 32'(cyc - r), 32'd1);
      check("first_busy", 32'(sched_busy), 32'd1);
      wait_ack(100, a);
      check("first_ack", 32'(ack), 32'h01);
      check("first_result", 32'(result), 32'h100);
      req = '0;

      // Round-robin order over a sparse request pattern
      req = 8'hA5;
      do_reset();
      a = 0;
      for (int k = 0; k < 5; k++) begin
         wait_start(100, s);
         if (k > 0) check("rr_gap0", 32'(s - a), 32'd2);
         check("rr_ch", 32'(conv_ch), 32'(exp_ch[k]));
         wait_ack(100, a);
         check("rr_ack", 32'(ack), 32'd1 << exp_ch[k]);
         check("rr_result", 32'(result), 32'h100 + 32'(exp_ch[k]));
         check("rr_err", 32'(err), 32'd0);
         check("rr_latency", 32'(a - s), 32'(ENG_LAT + 1));
         @(negedge clock);
         check("rr_ack_one_cycle", 32'(ack), 32'd0);
         check("rr_result_hold", 32'(result), 32'h100 + 32'(exp_ch[k]));
      end
      req = '0;

      // Requests only on disabled channels never start a conversion
      enable = 8'h0F;
      req    = 8'hF0;
      do_reset();
      seen_start = 1'b0;
      seen_busy  = 1'b0;
      repeat (500) begin
         @(negedge clock);
         if (conv_start) seen_start = 1'b1;
         if (sched_busy) seen_busy = 1'b1;
      end
      check("masked_no_start", 32'(seen_start), 32'd0);
      check("masked_no_busy", 32'(seen_busy), 32'd0);
      enable = 8'hFF;
      req    = 8'h00;

      // Minimum gap between ACK and next start, sampled at response time
      min_gap = 16'd10;
      req     = 8'h01;
      wait_start(100, s);
      wait_ack(100, a);
      check("gap_ack", 32'(ack), 32'h01);
      wait_start(100, s2);
      check("gap10", 32'(s2 - a), 32'd12);
      min_gap = 16'd0;
      wait_ack(100, a2);
      wait_start(100, s);
      check("gap0", 32'(s - a2), 32'd2);

      // Engine busy holds off the next start
      wait_ack(100, a);
      conv_busy  = 1'b1;
      seen_start = 1'b0;
      repeat (15) begin
         @(negedge clock);
         if (conv_start) seen_start = 1'b1;
      end
      check("busy_blocks", 32'(seen_start), 32'd0);
      conv_busy = 1'b0;
      b = cyc;
      wait_start(100, s);
      check("busy_release", 32'(s - b), 32'd1);
      wait_ack(100, a);
      check("busy_ack", 32'(ack), 32'h01);

      // Watchdog expiry, then a real result clears ERR
      eng_hang = 1'b1;
      wait_start(100, s);
      wait_ack(200, a);
      check("to_latency", 32'(a - s), 32'(TIMEOUT + 1));
      check("to_ack", 32'(ack), 32'h01);
      check("to_err", 32'(err), 32'd1);
      check("to_result", 32'(result), 32'd0);
      eng_hang = 1'b0;
      wait_ack(200, a);
      check("to_recover_err", 32'(err), 32'd0);
      check("to_recover_result", 32'(result), 32'h100);
      req = '0;

      // Request withdrawn mid-conversion: no ACK, pointer still advances
      req = 8'h08;
      do_reset();
      wait_start(100, s);
      check("drop_ch", 32'(conv_ch), 32'd3);
      repeat (2) @(negedge clock);
      req = '0;
      seen_ack = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (ack !== '0) seen_ack = 1'b1;
      end
      check("drop_no_ack", 32'(seen_ack), 32'd0);
      check("drop_idle", 32'(sched_busy), 32'd0);
      check("drop_result", 32'(result), 32'h103);
      req = 8'h11;
      wait_start(100, s);
      check("drop_ptr_next", 32'(conv_ch), 32'd4);
      wait_ack(100, a);
      check("drop_next_ack", 32'(ack), 32'h10);
      req = '0;

      // Reset during WAIT; the engine's late DONE must be ignored
      req = 8'h01;
      wait_start(100, s);
      repeat (5) @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("midrst_busy", 32'(sched_busy), 32'd0);
      check("midrst_ch", 32'(conv_ch), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      req = '0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      seen_dirty = 1'b0;
      repeat (30) begin
         @(negedge clock);
         if (ack !== '0 || sched_busy || err || result !== '0 || conv_start) seen_dirty = 1'b1;
      end
      check("late_done_ignored", 32'(seen_dirty), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
